// File: rtl/fpu_pkg.sv
// Shared FPU operand, classification and unrounded-result types.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fpu_float_fields_t;

    typedef struct packed {
        logic norm;
        logic zero;
        logic nan;
        logic inf;
    } fpu_float_conditions_t;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } fpu_round_mode_t;

    typedef struct packed {
        logic            sign;
        logic [23:0]     mantissa;
        logic [7:0]      exponent;
        logic [2:0]      guard;
        logic            nan;
        logic            inf;
        logic            zero;
        fpu_round_mode_t mode;
    } fpu_result_t;

endpackage

// File: rtl/fpu_div_iter_if.sv
// Operand/result handshake bundle for the iterative divider.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the
// sender keeps its payload stable while valid is high and ready is low.
interface fpu_div_iter_if;
    logic                           in_valid;
    logic                           in_ready;
    fpu_pkg::fpu_float_fields_t     a;
    fpu_pkg::fpu_float_fields_t     b;
    fpu_pkg::fpu_float_conditions_t conditions_A;
    fpu_pkg::fpu_float_conditions_t conditions_B;
    fpu_pkg::fpu_round_mode_t       mode;
    logic                           out_valid;
    logic                           out_ready;
    fpu_pkg::fpu_result_t           result;

    modport slave (
        input  in_valid, a, b, conditions_A, conditions_B, mode, out_ready,
        output in_ready, out_valid, result
    );

    modport master (
        output in_valid, a, b, conditions_A, conditions_B, mode, out_ready,
        input  in_ready, out_valid, result
    );
endinterface

// File: rtl/fpu_div_iter.sv
// Iterative single-precision divider: radix-2 restoring loop, one quotient bit
// per cycle, producing the unrounded result for the shared rounding stage.
module fpu_div_iter
    import fpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fpu_div_iter_if.slave bus,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [4:0]        cnt;
    logic [24:0]       rem;
    logic [23:0]       div_r;
    logic [26:0]       q;
    logic signed [9:0] exp_r;
    logic              sign_r;
    fpu_round_mode_t   mode_r;
    fpu_result_t       res_r;
    logic              out_valid_r;

    // Denormals carry no norm/nan/inf flag and are folded into zero.
    logic a_zero, b_zero, sp_nan, sp_inf, sp_zero, special;
    assign a_zero  = ~(bus.conditions_A.norm | bus.conditions_A.nan | bus.conditions_A.inf);
    assign b_zero  = ~(bus.conditions_B.norm | bus.conditions_B.nan | bus.conditions_B.inf);
    assign sp_nan  = bus.conditions_A.nan | bus.conditions_B.nan |
                     (a_zero & b_zero) | (bus.conditions_A.inf & bus.conditions_B.inf);
    assign sp_inf  = ~sp_nan & (bus.conditions_A.inf | b_zero);
    assign sp_zero = ~sp_nan & (a_zero | bus.conditions_B.inf);
    assign special = sp_nan | sp_inf | sp_zero;

    logic signed [9:0] exp_calc;
    assign exp_calc = $signed({2'b00, bus.a.exponent}) - $signed({2'b00, bus.b.exponent}) + 10'sd127;

    logic        rem_ge;
    logic [24:0] rem_next;
    assign rem_ge   = (rem >= {1'b0, div_r});
    assign rem_next = rem_ge ? (rem - {1'b0, div_r}) : rem;

    // Quotient sits in (0.5, 2); a clear integer bit costs one exponent step.
    logic              sticky;
    logic signed [9:0] exp_norm;
    logic [23:0]       mant_norm;
    logic [2:0]        guard_norm;
    assign sticky     = (rem != 25'd0);
    assign exp_norm   = q[26] ? exp_r : (exp_r - 10'sd1);
    assign mant_norm  = q[26] ? q[26:3] : q[25:2];
    assign guard_norm = q[26] ? {q[2], q[1], q[0] | sticky} : {q[1], q[0], sticky};

    fpu_result_t norm_res, special_res;
    always_comb begin
        norm_res      = '0;
        norm_res.sign = sign_r;
        norm_res.mode = mode_r;
        if (exp_norm >= 10'sd255) begin
            norm_res.inf = 1'b1;
        end else if (exp_norm <= 10'sd0) begin
            norm_res.zero = 1'b1;
        end else begin
            norm_res.mantissa = mant_norm;
            norm_res.exponent = exp_norm[7:0];
            norm_res.guard    = guard_norm;
        end
    end

    always_comb begin
        special_res      = '0;
        special_res.sign = bus.a.sign ^ bus.b.sign;
        special_res.mode = bus.mode;
        special_res.nan  = sp_nan;
        special_res.inf  = sp_inf;
        special_res.zero = sp_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            div_r       <= '0;
            q           <= '0;
            exp_r       <= '0;
            sign_r      <= 1'b0;
            mode_r      <= RNE;
            res_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r <= bus.a.sign ^ bus.b.sign;
                        mode_r <= bus.mode;
                        if (special) begin
                            res_r       <= special_res;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            rem   <= {2'b01, bus.a.mantissa};
                            div_r <= {1'b1, bus.b.mantissa};
                            q     <= '0;
                            cnt   <= '0;
                            exp_r <= exp_calc;
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    q   <= {q[25:0], rem_ge};
                    rem <= {rem_next[23:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd26) state <= NORM;
                end
                NORM: begin
                    res_r       <= norm_res;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = res_r;
    assign dbg_state     = state;

endmodule

// File: tb/tb_fpu_div_iter.sv
// Bench for fpu_div_iter: directed vector table, handshake/reset sequences and
// random operands checked against an arithmetic quotient model.
module tb_fpu_div_iter;
    import fpu_pkg::*;

    localparam int W = $bits(fpu_result_t);

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    fpu_div_iter_if bus();

    fpu_div_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic fpu_float_conditions_t classify(input logic [31:0] f);
        fpu_float_conditions_t c;
        c = '0;
        if (f[30:23] == 8'd0 && f[22:0] == 23'd0) c.zero = 1'b1;
        else if (f[30:23] == 8'd255 && f[22:0] == 23'd0) c.inf = 1'b1;
        else if (f[30:23] == 8'd255) c.nan = 1'b1;
        else if (f[30:23] != 8'd0) c.norm = 1'b1;
        return c;
    endfunction

    // Reference: exact integer quotient of the two significands, then the
    // normalise/range rules applied with plain arithmetic.
    function automatic fpu_result_t model_div(input logic [31:0] fa, input logic [31:0] fb,
                                              input fpu_round_mode_t m, output int lat);
        fpu_result_t r;
        bit az, bz, ainf, binf, anan, bnan, sticky;
        int e;
        longint unsigned n, d, qq, rr;
        r = '0;
        r.sign = fa[31] ^ fb[31];
        r.mode = m;
        az   = (fa[30:23] == 8'd0);
        bz   = (fb[30:23] == 8'd0);
        ainf = (fa[30:0] == 31'h7F800000);
        binf = (fb[30:0] == 31'h7F800000);
        anan = (fa[30:23] == 8'd255) && !ainf;
        bnan = (fb[30:23] == 8'd255) && !binf;
        lat  = 1;
        if (anan || bnan || (az && bz) || (ainf && binf)) r.nan = 1'b1;
        else if (ainf || bz) r.inf = 1'b1;
        else if (az || binf) r.zero = 1'b1;
        else begin
            lat = 29;
            e  = int'(fa[30:23]) - int'(fb[30:23]) + 127;
            n  = {40'd0, 1'b1, fa[22:0]};
            n  = n << 26;
            d  = {40'd0, 1'b1, fb[22:0]};
            qq = n / d;
            rr = n % d;
            sticky = (rr != 0);
            if (qq >= (64'd1 << 26)) begin
                r.mantissa = 24'(qq >> 3);
                r.guard    = 3'(qq & 7) | {2'b00, sticky};
            end else begin
                e = e - 1;
                r.mantissa = 24'(qq >> 2);
                r.guard    = 3'((qq & 3) << 1) | {2'b00, sticky};
            end
            if (e >= 255) begin
                r.inf = 1'b1; r.mantissa = '0; r.guard = '0;
            end else if (e <= 0) begin
                r.zero = 1'b1; r.mantissa = '0; r.guard = '0;
            end else begin
                r.exponent = 8'(e);
            end
        end
        return r;
    endfunction

    function automatic fpu_result_t mk_res(input logic s, input logic [23:0] mt, input logic [7:0] ex,
                                           input logic [2:0] g, input logic nn, input logic nf,
                                           input logic zr, input fpu_round_mode_t m);
        fpu_result_t r;
        r = '0;
        r.sign = s; r.mantissa = mt; r.exponent = ex; r.guard = g;
        r.nan = nn; r.inf = nf; r.zero = zr; r.mode = m;
        return r;
    endfunction

    // driver tasks
    task automatic drive_ops(input logic [31:0] fa, input logic [31:0] fb, input fpu_round_mode_t m);
        bus.a            = fa;
        bus.b            = fb;
        bus.conditions_A = classify(fa);
        bus.conditions_B = classify(fb);
        bus.mode         = m;
    endtask

    task automatic start_op(input logic [31:0] fa, input logic [31:0] fb, input fpu_round_mode_t m);
        int n;
        @(negedge clk);
        drive_ops(fa, fb, m);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [31:0] fa, input logic [31:0] fb,
                             input fpu_round_mode_t m, input fpu_result_t expr, input int exp_lat);
        int lat;
        logic [W-1:0] e;
        exp_q.push_back(expr);
        start_op(fa, fb, m);
        wait_valid(lat);
        e = exp_q.pop_front();
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_result"}, 64'(bus.result), 64'(e));
        handshake();
    endtask

    typedef struct {
        string           name;
        logic [31:0]     a;
        logic [31:0]     b;
        fpu_round_mode_t mode;
        fpu_result_t     expr;
        int              lat;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] specials[6];

    initial begin
        int lat;
        fpu_result_t r6, r13;
        logic [31:0] fa, fb;
        fpu_round_mode_t m;
        fpu_result_t er;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive_ops(32'h0, 32'h0, RNE);
        rst_n = 1'b0;

        r6  = mk_res(0, 24'h800000, 8'd128, 3'b000, 0, 0, 0, RNE);
        r13 = mk_res(0, 24'hAAAAAA, 8'd125, 3'b101, 0, 0, 0, RNE);
        vecs.push_back('{"div_6_3",      32'h40C00000, 32'h40400000, RNE, r6, 29});
        vecs.push_back('{"div_1_3",      32'h3F800000, 32'h40400000, RNE, r13, 29});
        vecs.push_back('{"div_1_m3",     32'h3F800000, 32'hC0400000, RMM,
                         mk_res(1, 24'hAAAAAA, 8'd125, 3'b101, 0, 0, 0, RMM), 29});
        vecs.push_back('{"zero_zero",    32'h00000000, 32'h00000000, RNE, mk_res(0, 0, 0, 0, 1, 0, 0, RNE), 1});
        vecs.push_back('{"inf_inf",      32'h7F800000, 32'h7F800000, RNE, mk_res(0, 0, 0, 0, 1, 0, 0, RNE), 1});
        vecs.push_back('{"one_zero",     32'h3F800000, 32'h00000000, RTZ, mk_res(0, 0, 0, 0, 0, 1, 0, RTZ), 1});
        vecs.push_back('{"zero_five",    32'h00000000, 32'h40A00000, RNE, mk_res(0, 0, 0, 0, 0, 0, 1, RNE), 1});
        vecs.push_back('{"denorm_two",   32'h00000001, 32'h40000000, RNE, mk_res(0, 0, 0, 0, 0, 0, 1, RNE), 1});
        vecs.push_back('{"nan_one",      32'h7FC00000, 32'h3F800000, RUP, mk_res(0, 0, 0, 0, 1, 0, 0, RUP), 1});
        vecs.push_back('{"overflow",     32'h7F000000, 32'h00800000, RNE, mk_res(0, 0, 0, 0, 0, 1, 0, RNE), 29});
        vecs.push_back('{"underflow",    32'h00800000, 32'h7F000000, RNE, mk_res(0, 0, 0, 0, 0, 0, 1, RNE), 29});
        vecs.push_back('{"exp_255",      32'h7F000000, 32'h3F000000, RNE, mk_res(0, 0, 0, 0, 0, 1, 0, RNE), 29});
        vecs.push_back('{"exp_0_norm",   32'h00800000, 32'h3F800001, RNE, mk_res(0, 0, 0, 0, 0, 0, 1, RNE), 29});
        vecs.push_back('{"exp_1",        32'h00800000, 32'h3F800000, RDN,
                         mk_res(0, 24'h800000, 8'd1, 3'b000, 0, 0, 0, RDN), 29});

        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000005};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < vecs.size(); i++)
            run_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].expr, vecs[i].lat);

        // backpressure: result held, in_ready low, in_valid pulses ignored
        start_op(32'h40C00000, 32'h40400000, RNE);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd29);
        for (int k = 0; k < 5; k++) begin
            drive_ops(32'h3F800000, 32'h40400000, RTZ);
            bus.in_valid = (k % 2 == 0);
            check("bp_result", 64'(bus.result), 64'(r6));
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("bp_result_end", 64'(bus.result), 64'(r6));
        handshake();
        check("bp_out_valid_after", 64'(bus.out_valid), 64'd0);
        check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
        run_check("bp_second", 32'h3F800000, 32'h40400000, RNE, r13, 29);

        // reset in the middle of DIVIDE
        start_op(32'h40C00000, 32'h40400000, RNE);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_result", 64'(bus.result), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_check("post_rst_6_3", 32'h40C00000, 32'h40400000, RNE, r6, 29);

        // random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            fa = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            fb = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            if ($urandom_range(0, 4) == 0) fa = specials[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) fb = specials[$urandom_range(0, 5)];
            m  = fpu_round_mode_t'($urandom_range(0, 4));
            er = model_div(fa, fb, m, lat);
            run_check($sformatf("rand%0d", i), fa, fb, m, er, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
